// File: rtl/ddr2_init_seq.sv
// DDR2 power-up initialization sequencer. It owns the DFI control bus until the
// JEDEC init sequence completes, then forwards the scheduler's commands through one register stage.
module ddr2_init_seq #(
  parameter int CS_WIDTH   = 1,
  parameter int BA_WIDTH   = 3,
  parameter int ADDR_WIDTH = 14,
  parameter int T_INIT     = 80000,
  parameter int T_CKE      = 160,
  parameter int T_RP       = 6,
  parameter int T_MRD      = 2,
  parameter int T_RFC      = 51,
  parameter int T_DLL      = 200,
  parameter int MR_VAL     = 'h642,
  parameter int EMR1_VAL   = 'h004
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sch_cke,
  input  logic [CS_WIDTH-1:0]   sch_cs_n,
  input  logic                  sch_ras_n,
  input  logic                  sch_cas_n,
  input  logic                  sch_we_n,
  input  logic [BA_WIDTH-1:0]   sch_ba,
  input  logic [ADDR_WIDTH-1:0] sch_addr,
  input  logic                  sch_odt,
  output logic                  dfi_cke,
  output logic [CS_WIDTH-1:0]   dfi_cs_n,
  output logic                  dfi_ras_n,
  output logic                  dfi_cas_n,
  output logic                  dfi_we_n,
  output logic [BA_WIDTH-1:0]   dfi_ba,
  output logic [ADDR_WIDTH-1:0] dfi_addr,
  output logic                  dfi_odt,
  output logic                  init_done
);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max_int(max_int(max_int(T_INIT, T_CKE), max_int(T_RP, T_MRD)),
                                   max_int(T_RFC, T_DLL));
  // The counter only ever holds wait-1, so log2 of the largest wait is enough.
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [ADDR_WIDTH-1:0] PRE_ADDR       = ADDR_WIDTH'(32'h0000_0400);
  localparam logic [ADDR_WIDTH-1:0] MR_DLLRST_ADDR = ADDR_WIDTH'(MR_VAL | 32'h0000_0100);
  localparam logic [ADDR_WIDTH-1:0] MR_NORM_ADDR   = ADDR_WIDTH'(MR_VAL & ~32'h0000_0100);
  localparam logic [ADDR_WIDTH-1:0] EMR1_DEF_ADDR  = ADDR_WIDTH'(EMR1_VAL & ~32'h0000_0380);
  localparam logic [ADDR_WIDTH-1:0] EMR1_OCD_ADDR  = ADDR_WIDTH'(EMR1_VAL | 32'h0000_0380);

  typedef enum logic [3:0] {
    ST_RST_WAIT  = 4'd0,
    ST_CKE_WAIT  = 4'd1,
    ST_PRE1      = 4'd2,
    ST_EMR2      = 4'd3,
    ST_EMR3      = 4'd4,
    ST_EMR1_DLL  = 4'd5,
    ST_MR_DLLRST = 4'd6,
    ST_PRE2      = 4'd7,
    ST_REF1      = 4'd8,
    ST_REF2      = 4'd9,
    ST_MR        = 4'd10,
    ST_EMR1_OCD  = 4'd11,
    ST_EMR1_EXIT = 4'd12,
    ST_DONE      = 4'd13
  } state_t;

  function automatic logic [CNT_W-1:0] wait_load(input state_t st);
    case (st)
      ST_RST_WAIT:  return CNT_W'(T_INIT - 1);
      ST_CKE_WAIT:  return CNT_W'(T_CKE - 1);
      ST_PRE1,
      ST_PRE2:      return CNT_W'(T_RP - 1);
      ST_EMR2,
      ST_EMR3,
      ST_EMR1_DLL,
      ST_MR_DLLRST,
      ST_EMR1_OCD,
      ST_EMR1_EXIT: return CNT_W'(T_MRD - 1);
      ST_REF1,
      ST_REF2:      return CNT_W'(T_RFC - 1);
      ST_MR:        return CNT_W'(T_DLL - 1);
      default:      return {CNT_W{1'b0}};
    endcase
  endfunction

  function automatic state_t next_step(input state_t st);
    case (st)
      ST_RST_WAIT:  return ST_CKE_WAIT;
      ST_CKE_WAIT:  return ST_PRE1;
      ST_PRE1:      return ST_EMR2;
      ST_EMR2:      return ST_EMR3;
      ST_EMR3:      return ST_EMR1_DLL;
      ST_EMR1_DLL:  return ST_MR_DLLRST;
      ST_MR_DLLRST: return ST_PRE2;
      ST_PRE2:      return ST_REF1;
      ST_REF1:      return ST_REF2;
      ST_REF2:      return ST_MR;
      ST_MR:        return ST_EMR1_OCD;
      ST_EMR1_OCD:  return ST_EMR1_EXIT;
      ST_EMR1_EXIT: return ST_DONE;
      ST_DONE:      return ST_DONE;
      default:      return ST_RST_WAIT;
    endcase
  endfunction

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic                    enter_s;
  logic                    c_ras_s, c_cas_s, c_we_s;
  logic [BA_WIDTH-1:0]     c_ba_s;
  logic [ADDR_WIDTH-1:0]   c_addr_s;
  logic                    cke_s, ras_s, cas_s, we_s, odt_s;
  logic [CS_WIDTH-1:0]     cs_n_s;
  logic [BA_WIDTH-1:0]     ba_s;
  logic [ADDR_WIDTH-1:0]   addr_s;

  // Next state and wait counter: each state lasts exactly its wait, the counter reloads on entry.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (state_r == ST_DONE) begin
      state_s = ST_DONE;
      cnt_s   = cnt_r;
    end else if (cnt_r == {CNT_W{1'b0}}) begin
      state_s = next_step(state_r);
      cnt_s   = wait_load(state_s);
    end else begin
      cnt_s = cnt_r - CNT_W'(1'b1);
    end
  end

  // Command fields issued on the single cycle a command state is entered.
  always_comb begin
    c_ras_s  = 1'b1;
    c_cas_s  = 1'b1;
    c_we_s   = 1'b1;
    c_ba_s   = {BA_WIDTH{1'b0}};
    c_addr_s = {ADDR_WIDTH{1'b0}};
    case (state_s)
      ST_PRE1, ST_PRE2: begin
        c_ras_s = 1'b0; c_we_s = 1'b0; c_addr_s = PRE_ADDR;
      end
      ST_EMR2: begin
        c_ras_s = 1'b0; c_cas_s = 1'b0; c_we_s = 1'b0; c_ba_s = BA_WIDTH'(2'd2);
      end
      ST_EMR3: begin
        c_ras_s = 1'b0; c_cas_s = 1'b0; c_we_s = 1'b0; c_ba_s = BA_WIDTH'(2'd3);
      end
      ST_EMR1_DLL, ST_EMR1_EXIT: begin
        c_ras_s = 1'b0; c_cas_s = 1'b0; c_we_s = 1'b0; c_ba_s = BA_WIDTH'(2'd1);
        c_addr_s = EMR1_DEF_ADDR;
      end
      ST_EMR1_OCD: begin
        c_ras_s = 1'b0; c_cas_s = 1'b0; c_we_s = 1'b0; c_ba_s = BA_WIDTH'(2'd1);
        c_addr_s = EMR1_OCD_ADDR;
      end
      ST_MR_DLLRST: begin
        c_ras_s = 1'b0; c_cas_s = 1'b0; c_we_s = 1'b0; c_addr_s = MR_DLLRST_ADDR;
      end
      ST_MR: begin
        c_ras_s = 1'b0; c_cas_s = 1'b0; c_we_s = 1'b0; c_addr_s = MR_NORM_ADDR;
      end
      ST_REF1, ST_REF2: begin
        c_ras_s = 1'b0; c_cas_s = 1'b0;
      end
      default: begin
        c_ras_s = 1'b1;
      end
    endcase
  end

  // Bus mux: scheduler pass-through in DONE, deselect while CKE is low, command or NOP otherwise.
  always_comb begin
    enter_s = (state_s != state_r);
    cke_s   = 1'b1;
    cs_n_s  = {CS_WIDTH{1'b0}};
    ras_s   = 1'b1;
    cas_s   = 1'b1;
    we_s    = 1'b1;
    ba_s    = {BA_WIDTH{1'b0}};
    addr_s  = {ADDR_WIDTH{1'b0}};
    odt_s   = 1'b0;
    if (state_s == ST_DONE) begin
      cke_s  = sch_cke;
      cs_n_s = sch_cs_n;
      ras_s  = sch_ras_n;
      cas_s  = sch_cas_n;
      we_s   = sch_we_n;
      ba_s   = sch_ba;
      addr_s = sch_addr;
      odt_s  = sch_odt;
    end else if (state_s == ST_RST_WAIT) begin
      cke_s  = 1'b0;
      cs_n_s = {CS_WIDTH{1'b1}};
    end else if (enter_s) begin
      ras_s  = c_ras_s;
      cas_s  = c_cas_s;
      we_s   = c_we_s;
      ba_s   = c_ba_s;
      addr_s = c_addr_s;
    end else begin
      ras_s = 1'b1;
    end
  end

  // State, counter and registered DFI outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RST_WAIT;
      cnt_r     <= wait_load(ST_RST_WAIT);
      dfi_cke   <= 1'b0;
      dfi_cs_n  <= {CS_WIDTH{1'b1}};
      dfi_ras_n <= 1'b1;
      dfi_cas_n <= 1'b1;
      dfi_we_n  <= 1'b1;
      dfi_ba    <= {BA_WIDTH{1'b0}};
      dfi_addr  <= {ADDR_WIDTH{1'b0}};
      dfi_odt   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      dfi_cke   <= cke_s;
      dfi_cs_n  <= cs_n_s;
      dfi_ras_n <= ras_s;
      dfi_cas_n <= cas_s;
      dfi_we_n  <= we_s;
      dfi_ba    <= ba_s;
      dfi_addr  <= addr_s;
      dfi_odt   <= odt_s;
      init_done <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Directed bench for ddr2_init_seq: checks every cycle of the init sequence
// against a hand-written command table, the handover to the scheduler, and reset in mid-sequence and in DONE.
module tb_ddr2_init_seq;

  logic        clk;
  logic        rst;
  logic        sch_cke, sch_ras_n, sch_cas_n, sch_we_n, sch_odt;
  logic [1:0]  sch_cs_n;
  logic [2:0]  sch_ba;
  logic [13:0] sch_addr;
  logic        dfi_cke, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt, init_done;
  logic [1:0]  dfi_cs_n;
  logic [2:0]  dfi_ba;
  logic [13:0] dfi_addr;

  int n_vec  = 0;
  int n_miss = 0;

  ddr2_init_seq #(
    .CS_WIDTH(2), .BA_WIDTH(3), .ADDR_WIDTH(14),
    .T_INIT(10), .T_CKE(4), .T_RP(3), .T_MRD(2), .T_RFC(5), .T_DLL(6),
    .MR_VAL('h642), .EMR1_VAL('h004)
  ) dut (
    .clk(clk), .rst(rst),
    .sch_cke(sch_cke), .sch_cs_n(sch_cs_n), .sch_ras_n(sch_ras_n), .sch_cas_n(sch_cas_n),
    .sch_we_n(sch_we_n), .sch_ba(sch_ba), .sch_addr(sch_addr), .sch_odt(sch_odt),
    .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n),
    .dfi_we_n(dfi_we_n), .dfi_ba(dfi_ba), .dfi_addr(dfi_addr), .dfi_odt(dfi_odt),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle numbers count clock edges after the last edge that saw rst high.
  localparam int DONE_CYC = 48;
  localparam int CKE_CYC  = 10;
  localparam int CMD_K    [11] = '{14, 17, 19, 21, 23, 25, 28, 33, 38, 44, 46};
  localparam logic [2:0]  CMD_RCW  [11] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010,
                                            3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
  localparam logic [2:0]  CMD_BA   [11] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
  localparam logic [13:0] CMD_ADDR [11] = '{14'h400, 14'h000, 14'h000, 14'h004, 14'h742, 14'h400,
                                            14'h000, 14'h000, 14'h642, 14'h384, 14'h004};
  localparam int GAPS     [11] = '{4, 3, 2, 2, 2, 2, 3, 5, 5, 6, 2};

  function automatic logic [31:0] pack(input logic cke, input logic [1:0] cs, input logic [2:0] rcw,
                                       input logic [2:0] ba, input logic [13:0] addr,
                                       input logic odt, input logic done);
    return {7'd0, cke, cs, rcw, ba, addr, odt, done};
  endfunction

  localparam logic [31:0] RST_VEC = {7'd0, 1'b0, 2'b11, 3'b111, 3'd0, 14'h0000, 1'b0, 1'b0};
  localparam logic [31:0] ACT_VEC = {7'd0, 1'b1, 2'b00, 3'b011, 3'd5, 14'h1234, 1'b0, 1'b1};

  function automatic logic [31:0] obs_vec();
    return pack(dfi_cke, dfi_cs_n, {dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_ba, dfi_addr, dfi_odt, init_done);
  endfunction

  function automatic logic [31:0] exp_init(input int k);
    if (k < CKE_CYC) return RST_VEC;
    if (k >= DONE_CYC) return ACT_VEC;
    for (int i = 0; i < 11; i++)
      if (CMD_K[i] == k) return pack(1'b1, 2'b00, CMD_RCW[i], CMD_BA[i], CMD_ADDR[i], 1'b0, 1'b0);
    return pack(1'b1, 2'b00, 3'b111, 3'd0, 14'h0000, 1'b0, 1'b0);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sch(input logic cke, input logic [1:0] cs, input logic [2:0] rcw,
                         input logic [2:0] ba, input logic [13:0] addr, input logic odt);
    sch_cke = cke; sch_cs_n = cs; {sch_ras_n, sch_cas_n, sch_we_n} = rcw;
    sch_ba = ba; sch_addr = addr; sch_odt = odt;
  endtask

  task automatic set_act();
    set_sch(1'b1, 2'b00, 3'b011, 3'd5, 14'h1234, 1'b0);
  endtask

  // Checks ncyc cycles after release; a full run also checks the command spacing.
  task automatic run_seq(input int ncyc, input string name);
    int cmd_cyc[$];
    int cke_rise;
    int prev;
    cke_rise = -1;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      check_val($sformatf("%s c%0d", name, k), obs_vec(), exp_init(k));
      if (dfi_cke && cke_rise < 0) cke_rise = k;
      if (dfi_cke && !init_done && {dfi_ras_n, dfi_cas_n, dfi_we_n} != 3'b111) cmd_cyc.push_back(k);
    end
    if (ncyc > DONE_CYC) begin
      check_val({name, " cke_rise"}, 32'(cke_rise), 32'(CKE_CYC));
      check_val({name, " ncmd"}, 32'(cmd_cyc.size()), 32'd11);
      for (int i = 0; i < 11; i++) begin
        if (i < cmd_cyc.size()) begin
          prev = (i == 0) ? cke_rise : cmd_cyc[i-1];
          check_val($sformatf("%s gap%0d", name, i), 32'(cmd_cyc[i] - prev), 32'(GAPS[i]));
        end else begin
          check_val($sformatf("%s gap%0d", name, i), 32'hFFFF_FFFF, 32'(GAPS[i]));
        end
      end
    end
  endtask

  // Scheduler changes every cycle; dfi must lag by exactly one edge.
  task automatic track(input string name);
    logic [31:0] prev_v;
    logic [31:0] want;
    prev_v = ACT_VEC;
    for (int i = 1; i <= 6; i++) begin
      set_sch(i[0], i[1:0], i[2:0] ^ 3'b101, i[2:0], 14'(14'h100 * i + 14'h21), ~i[0]);
      want = pack(sch_cke, sch_cs_n, {sch_ras_n, sch_cas_n, sch_we_n}, sch_ba, sch_addr, sch_odt, 1'b1);
      #2;
      check_val($sformatf("%s hold%0d", name, i), obs_vec(), prev_v);
      tick();
      check_val($sformatf("%s pass%0d", name, i), obs_vec(), want);
      prev_v = want;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_act();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("rst hold%0d", i), obs_vec(), RST_VEC);
    end
    rst = 1'b0;

    // Partial run, then a one-cycle reset during the REF1 wait.
    run_seq(30, "pre_mid");
    rst = 1'b1;
    tick();
    check_val("mid rst", obs_vec(), RST_VEC);
    rst = 1'b0;

    run_seq(DONE_CYC + 2, "full1");
    track("trk1");

    set_sch(1'b1, 2'b01, 3'b010, 3'd6, 14'h2ABC, 1'b1);
    rst = 1'b1;
    tick();
    check_val("done rst", obs_vec(), RST_VEC);
    set_act();
    rst = 1'b0;
    run_seq(DONE_CYC + 2, "full2");
    track("trk2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
